sram_load_arbiter: RTL

SRAM_LOAD_ARBITER -- requirements
Module: sram_load_arbiter

---
 rtl/sram_load_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sram_load_arbiter.sv
// Loads a byte stream into an asynchronous SRAM while sharing the RAM with a console.
// The console gets the RAM whenever no write cycle (setup/strobe/hold) is in flight.
module sram_load_arbiter #(
  parameter int unsigned WR_PULSE = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LD_START,
  input  logic [14:0] LD_BASE,
  input  logic [14:0] LD_LEN,
  input  logic [7:0]  LD_DATA,
  input  logic        LD_VALID,
  output logic        LD_READY,
  output logic        LD_DONE,
  output logic        BUSY,
  input  logic        CON_PSEN,
  input  logic [14:0] CON_A,
  output logic        CON_GRANT,
  output logic [14:0] RAMA,
  output logic [7:0]  RAMD_OUT,
  output logic        RAMD_OE,
  output logic        RAMWE,
  output logic        RAMOE,
  output logic        RAMCS
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } state_e;

  localparam logic [3:0] PulseLast = 4'(WR_PULSE - 1);

  state_e      state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [14:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  pulse_q, pulse_d;
  logic        sync1_q, sync2_q;

  logic [14:0] rama_q, rama_d;
  logic        ramwe_q, ramwe_d;
  logic        ramoe_q, ramoe_d;
  logic        ramcs_q, ramcs_d;
  logic        ramd_oe_q, ramd_oe_d;
  logic        grant_q, grant_d;

  logic con_req;
  logic accept;
  logic write_d;

  assign con_req  = ~sync2_q;
  assign LD_READY = (state_q == StArmed) && !con_req;
  assign accept   = LD_READY && LD_VALID;
  assign LD_DONE  = (state_q == StDone);
  assign BUSY     = (state_q inside {StArmed, StSetup, StStrobe, StHold});

  assign RAMA      = rama_q;
  assign RAMD_OUT  = data_q;
  assign RAMD_OE   = ramd_oe_q;
  assign RAMWE     = ramwe_q;
  assign RAMOE     = ramoe_q;
  assign RAMCS     = ramcs_q;
  assign CON_GRANT = grant_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      pulse_q   <= '0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rama_q    <= '0;
      ramwe_q   <= 1'b1;
      ramoe_q   <= 1'b1;
      ramcs_q   <= 1'b1;
      ramd_oe_q <= 1'b0;
      grant_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      pulse_q   <= pulse_d;
      sync1_q   <= CON_PSEN;
      sync2_q   <= sync1_q;
      rama_q    <= rama_d;
      ramwe_q   <= ramwe_d;
      ramoe_q   <= ramoe_d;
      ramcs_q   <= ramcs_d;
      ramd_oe_q <= ramd_oe_d;
      grant_q   <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pulse_d = pulse_q;
    unique case (state_q)
      StIdle: begin
        if (LD_START) begin
          if (LD_LEN != '0) begin
            addr_d  = LD_BASE;
            cnt_d   = LD_LEN;
            state_d = StArmed;
          end else begin
            state_d = StDone;
          end
        end
      end
      StArmed: begin
        if (accept) begin
          data_d  = LD_DATA;
          state_d = StSetup;
        end
      end
      StSetup: begin
        pulse_d = PulseLast;
        state_d = StStrobe;
      end
      StStrobe: begin
        if (pulse_q == '0) begin
          state_d = StHold;
        end else begin
          pulse_d = pulse_q - 4'd1;
        end
      end
      StHold: begin
        addr_d  = addr_q + 15'd1;
        cnt_d   = cnt_q - 15'd1;
        state_d = (cnt_q == 15'd1) ? StDone : StArmed;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output registers are fed from the next state so they line up with state_q.
  always_comb begin
    write_d   = (state_d inside {StSetup, StStrobe, StHold});
    rama_d    = addr_d;
    ramwe_d   = 1'b1;
    ramoe_d   = 1'b1;
    ramcs_d   = 1'b1;
    ramd_oe_d = 1'b0;
    grant_d   = 1'b0;
    if (write_d) begin
      ramcs_d   = 1'b0;
      ramd_oe_d = 1'b1;
      ramwe_d   = (state_d != StStrobe);
    end else if (con_req) begin
      grant_d = 1'b1;
      rama_d  = CON_A;
      ramoe_d = 1'b0;
      ramcs_d = 1'b0;
    end
  end

endmodule
